// File: rtl/wm_pack_pkg.sv
// wm_pack_pkg: shared types and default geometry for the watermark pixel packer.
package wm_pack_pkg;
    localparam int AMBA_WORD  = 16;
    localparam int DATA_DEPTH = 8;
    localparam int PPW        = AMBA_WORD / DATA_DEPTH;

    typedef enum logic [1:0] {IDLE, FILL, FULL} pack_state_t;

    typedef struct packed {
        logic                 last;
        logic [PPW-1:0]       keep;
        logic [AMBA_WORD-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/wm_sync_fifo.sv
// wm_sync_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module wm_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] dout
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr + (AW+1)'(do_pop);
        end
endmodule

// File: rtl/wm_pixel_packer.sv
// wm_pixel_packer: packs watermark-core pixels into AMBA words, queues them with
// frame-end marking, and reports per-frame pixel totals and sticky overflow.
module wm_pixel_packer import wm_pack_pkg::*; #(
    parameter int Amba_Word  = AMBA_WORD,
    parameter int Data_Depth = DATA_DEPTH,
    parameter int Fifo_Depth = 8,
    parameter int Cnt_Width  = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              new_pixel,
    input  logic [Data_Depth-1:0]             Pixel_Data,
    input  logic                              Image_Done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [Amba_Word-1:0]              out_data,
    output logic [Amba_Word/Data_Depth-1:0]   out_keep,
    output logic                              out_last,
    output logic [Cnt_Width-1:0]              frame_pixels,
    output logic                              frame_done,
    output logic                              overflow
);
    localparam int LANES = Amba_Word / Data_Depth;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int EW    = 1 + LANES + Amba_Word;

    pack_state_t          state;
    logic [LW-1:0]        lane, idx;
    logic [Amba_Word-1:0] pack, data_a;
    logic [LANES-1:0]     keep_r, keep_a;
    logic [Cnt_Width-1:0] cnt, cnt_a;
    logic [EW-1:0]        pend_word, fin_word, push_word, head;
    logic                 pend, fresh, push_held, push, pop, full, empty;

    // Word as it stands after this cycle's pixel; FULL restarts at lane 0.
    always_comb begin
        fresh = state != FILL;
        idx   = fresh ? '0 : lane;
        data_a = pack;
        for (int l = 0; l < LANES; l++)
            data_a[l*Data_Depth +: Data_Depth] = !new_pixel ? pack[l*Data_Depth +: Data_Depth] :
                (idx == LW'(l)) ? Pixel_Data : fresh ? '0 : pack[l*Data_Depth +: Data_Depth];
        keep_a    = !new_pixel ? keep_r : (fresh ? '0 : keep_r) | (LANES'(1) << idx);
        push_held = new_pixel && state == FULL;
        fin_word  = {1'b1, keep_a, data_a};
        push      = pend || push_held || Image_Done;
        push_word = pend ? pend_word : push_held ? {1'b0, {LANES{1'b1}}, pack} : fin_word;
        cnt_a     = cnt + Cnt_Width'(new_pixel);
        pop       = !empty && out_ready;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            lane         <= '0;
            pack         <= '0;
            keep_r       <= '0;
            cnt          <= '0;
            pend         <= 1'b0;
            pend_word    <= '0;
            frame_pixels <= '0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // Held word and the frame-final word collide: the final one goes next cycle.
            pend       <= push_held && Image_Done;
            pend_word  <= fin_word;
            frame_done <= Image_Done;
            overflow   <= overflow || (push && full && !pop);
            cnt        <= Image_Done ? '0 : cnt_a;
            if (Image_Done) frame_pixels <= cnt_a;
            if (Image_Done) begin
                state  <= IDLE;
                lane   <= '0;
                pack   <= '0;
                keep_r <= '0;
            end else if (new_pixel) begin
                state  <= &keep_a ? FULL : FILL;
                lane   <= &keep_a ? '0 : idx + LW'(1);
                pack   <= data_a;
                keep_r <= keep_a;
            end
        end

    wm_sync_fifo #(.Width(EW), .Depth(Fifo_Depth)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_word),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign out_valid = !empty;
    assign {out_last, out_keep, out_data} = head;
endmodule

// File: tb/tb_wm_pixel_packer.sv
// tb_wm_pixel_packer: directed scoreboard bench for the pixel packer at default geometry.
module tb_wm_pixel_packer;
    import wm_pack_pkg::*;

    logic        clk = 0, rst = 1;
    logic        new_pixel = 0, Image_Done = 0, out_ready = 1;
    logic [7:0]  Pixel_Data = 0;
    logic        out_valid, out_last, frame_done, overflow;
    logic [15:0] out_data;
    logic [1:0]  out_keep;
    logic [23:0] frame_pixels;

    int checks = 0, passes = 0;
    fifo_entry_t sb[$];
    fifo_entry_t exp_w;

    wm_pixel_packer dut (
        .clk(clk), .rst(rst), .new_pixel(new_pixel), .Pixel_Data(Pixel_Data),
        .Image_Done(Image_Done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .frame_pixels(frame_pixels), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic step(input logic np, input logic [7:0] pd, input logic dn);
        new_pixel  = np;
        Pixel_Data = pd;
        Image_Done = dn;
        @(posedge clk);
        #1;
        new_pixel  = 0;
        Image_Done = 0;
    endtask

    task automatic expect_word(input logic last, input logic [1:0] keep, input logic [15:0] data);
        exp_w.last = last;
        exp_w.keep = keep;
        exp_w.data = data;
        sb.push_back(exp_w);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, 32'(sb.size()), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0)
                        $error("FAIL unexpected_word: got %h expected none", {out_last, out_keep, out_data});
                    else begin
                        exp_w = sb.pop_front();
                        assert ({out_last, out_keep, out_data} === exp_w) passes++;
                        else $error("FAIL word: got %h expected %h", {out_last, out_keep, out_data}, exp_w);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_outs", {13'(0), out_last, out_keep, out_data}, 0);
        chk("rst_status", {6'(0), frame_pixels, frame_done, overflow}, 0);
        rst = 0;
        @(posedge clk);
        #1;

        expect_word(0, 2'b11, 16'h2211);
        expect_word(1, 2'b11, 16'h4433);
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        step(1, 8'h44, 1);
        chk("basic_done", 32'(frame_done), 1);
        chk("basic_pixels", 32'(frame_pixels), 4);
        step(0, 0, 0);
        chk("basic_done_pulse", 32'(frame_done), 0);
        drain("basic_drain");

        expect_word(0, 2'b11, 16'hB2A1);
        expect_word(1, 2'b01, 16'h00C3);
        step(1, 8'hA1, 0);
        step(1, 8'hB2, 0);
        step(1, 8'hC3, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("odd_pixels", 32'(frame_pixels), 3);
        drain("odd_drain");

        expect_word(1, 2'b00, 16'h0000);
        step(0, 0, 1);
        chk("empty_pixels", 32'(frame_pixels), 0);
        chk("empty_done", 32'(frame_done), 1);
        drain("empty_drain");

        expect_word(0, 2'b11, 16'h0201);
        expect_word(1, 2'b01, 16'h0003);
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 1);
        chk("dbl_pixels", 32'(frame_pixels), 3);
        drain("dbl_drain");
        chk("no_overflow_yet", 32'(overflow), 0);

        out_ready = 0;
        for (int k = 0; k < 8; k++) expect_word(0, 2'b11, {8'(2*k+2), 8'(2*k+1)});
        for (int i = 1; i <= 20; i++) step(1, 8'(i), 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_valid", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("head_stable", {13'(0), out_last, out_keep, out_data}, {13'(0), 1'b0, 2'b11, 16'h0201});
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        drain("ovf_drain");
        expect_word(1, 2'b11, 16'h1413);
        step(0, 0, 1);
        chk("ovf_pixels", 32'(frame_pixels), 20);
        drain("ovf_tail_drain");
        chk("ovf_sticky", 32'(overflow), 1);

        out_ready = 0;
        step(1, 8'h31, 0);
        step(1, 8'h32, 0);
        step(1, 8'h33, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_outs", {13'(0), out_last, out_keep, out_data}, 0);
        chk("mid_rst_status", {6'(0), frame_pixels, frame_done, overflow}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        out_ready = 1;
        expect_word(1, 2'b11, 16'h6655);
        step(1, 8'h55, 0);
        step(1, 8'h66, 1);
        chk("post_rst_pixels", 32'(frame_pixels), 2);
        drain("post_rst_drain");
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
